// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame slave: FSM states, SPI mode and default frame sizes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACTIVE       = 2'd1,
    WAIT_CS_HIGH = 2'd2
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam int DEFAULT_RX_BITS = 768;
  localparam int DEFAULT_TX_BITS = 256;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses on the synchronised level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              last_q, last_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    last_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      last_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~last_q;
  assign fall = ~dout & last_q;

endmodule

// File: rtl/spi_frame_slave.sv
// Mode-0 SPI slave: receives fixed-length MOSI frames, returns a one-shot TX payload on MISO.
// Define SPI_FRAME_ERR_CNT_EN to build the saturating frame error counter (err_cnt reads 0 otherwise).
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int RX_BITS     = DEFAULT_RX_BITS,
  parameter int TX_BITS     = DEFAULT_TX_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [TX_BITS-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic [15:0]        err_cnt
);

  localparam int                CNT_W      = $clog2(RX_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RX_BITS);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RX_BITS + 1);
  localparam logic [1:0]        SETTLE_MAX = 2'(SYNC_STAGES);
  localparam logic              SAMPLE_ON_FALL = SPI_MODE0[1] ^ SPI_MODE0[0];
  // Bit order of the synchroniser vector: 0 = sclk, 1 = cs_n, 2 = mosi.
  localparam logic [2:0]        SYNC_RST   = 3'b010;

  logic [2:0] raw_in, sync_lvl, sync_rise, sync_fall;
  logic       unused_sync;

  assign raw_in = {mosi, cs_n, sclk};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_sync
    spi_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (SYNC_RST[gi])
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (raw_in[gi]),
      .dout (sync_lvl[gi]),
      .rise (sync_rise[gi]),
      .fall (sync_fall[gi])
    );
  end

  assign unused_sync = &{1'b0, sync_lvl[0], sync_rise[2], sync_fall[2]};

  logic sample_edge, shift_edge, cs_lvl, cs_rise, cs_fall, mosi_s;
  assign sample_edge = SAMPLE_ON_FALL ? sync_fall[0] : sync_rise[0];
  assign shift_edge  = SAMPLE_ON_FALL ? sync_rise[0] : sync_fall[0];
  assign cs_lvl      = sync_lvl[1];
  assign cs_rise     = sync_rise[1];
  assign cs_fall     = sync_fall[1];
  assign mosi_s      = sync_lvl[2];

  spi_state_e         state_q, state_d;
  logic [1:0]         settle_q, settle_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RX_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [RX_BITS-1:0] rx_data_q, rx_data_d;
  logic [TX_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [TX_BITS-1:0] hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               miso_q, miso_d;
  logic               miso_oe_q, miso_oe_d;

  always_comb begin
    state_d     = state_q;
    settle_d    = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 2'd1;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      // The synchroniser restarts from cs_n=1 after reset, so its level is only trusted once refilled.
      WAIT_CS_HIGH: begin
        if (settle_q == SETTLE_MAX && cs_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          tx_shift_d  = hold_full_q ? hold_q : '0;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CNT_FULL) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[RX_BITS-2:0], mosi_s};
            bit_cnt_d  = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
          end
          if (shift_edge) tx_shift_d = {tx_shift_q[TX_BITS-2:0], 1'b0};
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase

    // Capture is only possible while empty, so a same-cycle frame load has already taken zeros.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    miso_oe_d = (state_d == ACTIVE);
    miso_d    = miso_oe_d & tx_shift_d[TX_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_CS_HIGH;
      settle_q    <= '0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

`ifdef SPI_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: SPI master model at sclk = clk/8, frame table plus randomized frames vs a frame-level model.
module tb_spi_frame_slave;

  localparam int RXB = 768;
  localparam int TXB = 256;

  logic           clk = 1'b0;
  logic           rst, sclk, cs_n, mosi, miso, miso_oe;
  logic [TXB-1:0] tx_data;
  logic           tx_valid, tx_ready, rx_valid, frame_err;
  logic [RXB-1:0] rx_data;
  logic [15:0]    err_cnt;

  always #5 clk = ~clk;

  spi_frame_slave dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rxv_cnt  = 0;
  int ferr_cnt = 0;
  int stab_viol = 0;
  logic [RXB-1:0] rx_prev;

  // Frame-level reference state.
  logic [RXB-1:0] model_rx;
  logic [TXB-1:0] pend;
  bit             pend_valid;
  int             model_err;
  bit             miso_got [0:799];
  bit             oe_seen;

  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt++;
    if (frame_err) ferr_cnt++;
    if (!rst && rx_data !== rx_prev && !rx_valid) stab_viol++;
    rx_prev = rx_data;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [RXB-1:0] got, input logic [RXB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [799:0] rand_frame();
    logic [799:0] v;
    for (int k = 0; k < 25; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [TXB-1:0] rand256();
    logic [TXB-1:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic offer(input logic [TXB-1:0] p);
    int waitc;
    waitc = 0;
    @(posedge clk); #1;
    while (!tx_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("offer_tx_ready", tx_ready, 1);
    tx_data  = p;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("tx_ready_after_capture", tx_ready, 0);
    pend       = p;
    pend_valid = 1'b1;
  endtask

  task automatic do_frame(input string tag, input int nbits, input logic [799:0] data,
                          input bit inject, input logic [TXB-1:0] inj_pl, input int rst_at,
                          input bit exp_valid, input bit exp_err);
    logic [TXB-1:0] exp_pl;
    int mis;
    bit expb;
    exp_pl     = pend_valid ? pend : '0;
    pend_valid = 1'b0;
    rxv_cnt    = 0;
    ferr_cnt   = 0;
    oe_seen    = 1'b0;

    @(posedge clk); #1 cs_n = 1'b0;
    if (inject) begin
      // Two sync flops plus the edge detector: the load happens on the third clock edge after cs_n falls.
      @(posedge clk);
      @(posedge clk); #1;
      chk({tag, "_inject_tx_ready"}, tx_ready, 1);
      tx_data  = inj_pl;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid   = 1'b0;
      pend       = inj_pl;
      pend_valid = 1'b1;
      #50;
    end else begin
      #80;
    end

    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      if (i == rst_at) begin
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
      #40;
      miso_got[i] = miso;
      if (i == 0) oe_seen = miso_oe;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
    #40 cs_n = 1'b1;
    mosi = 1'b0;
    #100;

    if (rst_at >= 0) begin
      model_rx   = '0;
      model_err  = 0;
      pend_valid = 1'b0;
    end
    if (exp_valid) model_rx = data[RXB-1:0];
    if (exp_err) begin
`ifdef SPI_FRAME_ERR_CNT_EN
      if (model_err < 65535) model_err++;
`endif
    end

    chk({tag, "_rx_valid_pulses"}, rxv_cnt, exp_valid);
    chk({tag, "_frame_err_pulses"}, ferr_cnt, exp_err);
    chk({tag, "_rx_data"}, rx_data, model_rx);
    chk({tag, "_err_cnt"}, err_cnt, model_err);
    chk({tag, "_tx_ready"}, tx_ready, !pend_valid);
    chk({tag, "_miso_oe_active"}, oe_seen, 1);
    chk({tag, "_miso_idle"}, miso, 0);
    chk({tag, "_miso_oe_idle"}, miso_oe, 0);
    if (rst_at < 0) begin
      mis = 0;
      for (int i = 0; i < nbits; i++) begin
        expb = (i < TXB) ? exp_pl[TXB-1-i] : 1'b0;
        if (miso_got[i] != expb) mis++;
      end
      chk({tag, "_miso_stream_bad_bits"}, mis, 0);
    end
    $display("frame %s: bits=%0d rx_valid_pulses=%0d frame_err_pulses=%0d err_cnt=%0d",
             tag, nbits, rxv_cnt, ferr_cnt, err_cnt);
  endtask

  typedef struct {
    int nbits;
    int pl_kind;   // 0 none, 1 A5 pattern, 2 random
    bit pattern;   // 1: 0123..EF frame, 0: random frame
    bit inject;    // offer tx_data exactly on the synchronised cs_n fall
    bit exp_valid;
    bit exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [799:0]   pat, data;
    logic [TXB-1:0] a5;
    int             nb;
    bit             ev;

    vecs[0] = '{nbits: 768, pl_kind: 1, pattern: 1'b1, inject: 1'b0, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[1] = '{nbits: 700, pl_kind: 0, pattern: 1'b0, inject: 1'b0, exp_valid: 1'b0, exp_err: 1'b1};
    vecs[2] = '{nbits: 769, pl_kind: 2, pattern: 1'b0, inject: 1'b0, exp_valid: 1'b0, exp_err: 1'b1};
    vecs[3] = '{nbits: 768, pl_kind: 0, pattern: 1'b0, inject: 1'b0, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[4] = '{nbits: 768, pl_kind: 0, pattern: 1'b0, inject: 1'b1, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[5] = '{nbits: 768, pl_kind: 0, pattern: 1'b0, inject: 1'b0, exp_valid: 1'b1, exp_err: 1'b0};

    pat = '0;
    for (int k = 0; k < 12; k++) pat[64*k +: 64] = 64'h0123456789ABCDEF;
    a5 = {32{8'hA5}};

    model_rx   = '0;
    model_err  = 0;
    pend       = '0;
    pend_valid = 1'b0;

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_miso", miso, 0);
    chk("reset_miso_oe", miso_oe, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_rx_data", rx_data, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    for (int v = 0; v < 6; v++) begin
      data = vecs[v].pattern ? pat : rand_frame();
      if (vecs[v].pl_kind == 1)      offer(a5);
      else if (vecs[v].pl_kind == 2) offer(rand256());
      do_frame($sformatf("vec%0d", v), vecs[v].nbits, data, vecs[v].inject, rand256(), -1,
               vecs[v].exp_valid, vecs[v].exp_err);
    end

    // Reset pulsed at bit 300 with cs_n held low to the end of a full-length frame.
    do_frame("rst_mid", 768, rand_frame(), 1'b0, '0, 300, 1'b0, 1'b0);
    offer(rand256());
    do_frame("after_rst", 768, rand_frame(), 1'b0, '0, -1, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      nb = (r == 2) ? RXB : int'($urandom_range(1, 64));
      if ($urandom_range(0, 1) == 1) offer(rand256());
      ev = (nb == RXB);
      do_frame($sformatf("rand%0d", r), nb, rand_frame(), 1'b0, '0, -1, ev, !ev);
    end

    chk("rx_data_stable_outside_valid", stab_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
